bin_to_bcd_converter: RTL



---
 rtl/bin_to_bcd_converter.sv | 101 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces a 4-digit packed BCD word for the display stage. Values above
// 9999 saturate to 9999 and raise overflow.
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic [15:0]          BCD_code,
  output logic                 valid_BCD,
  output logic                 overflow
);

  localparam int CW = $clog2(BIN_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [BIN_WIDTH-1:0] shreg;
  logic [15:0]          scratch;
  logic [15:0]          scratch_adj;
  logic [CW-1:0]        count;
  logic                 ovf_pending;

  // Add 3 to every BCD digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit. A carry out of the
  // thousands digit is dropped; such inputs are already flagged as overflow.
  function automatic logic [15:0] dabble(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign scratch_adj = dabble(scratch);

  // State register; busy is registered alongside it so it tracks state != IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state logic: accept start only in IDLE, shift BIN_WIDTH times, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, shift-and-adjust in SHIFT, publish in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      BCD_code    <= 16'h0000;
      valid_BCD   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= bin_in;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= (32'(bin_in) > 32'd9999);
            valid_BCD   <= 1'b0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          count            <= count + 1'b1;
        end
        DONE: begin
          BCD_code  <= ovf_pending ? 16'h9999 : scratch;
          overflow  <= ovf_pending;
          valid_BCD <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
